// File: rtl/disp_pkg.sv
// Shared constants and FSM encoding for the display formatter and its consumer.
package disp_pkg;

  localparam int unsigned N_DIGITS = 8;
  localparam int unsigned VAL_W    = 27;
  localparam int unsigned BCD_W    = 4 * N_DIGITS;
  localparam int unsigned N_ITER   = VAL_W;

  localparam logic [VAL_W-1:0] MAX_VAL = 27'd99_999_999;

  // Display codes, also decoded by the display consumer.
  localparam logic [3:0] DEF_CODE_ERR = 4'h1;
  localparam logic [3:0] DEF_CODE_OVF = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/disp_formatter_if.sv
// Request/result bundle between the calculator and the display formatter.
interface disp_formatter_if;

  logic                        start;
  logic [disp_pkg::VAL_W-1:0]  value;
  logic [2:0]                  frac_digits;
  logic                        err;
  logic                        busy;
  logic                        latch;
  logic                        done;
  logic                        mode;
  logic [2:0]                  dp;
  logic [3:0]                  codes;
  logic [disp_pkg::BCD_W-1:0]  num;

  modport master (
    output start, value, frac_digits, err,
    input  busy, latch, done, mode, dp, codes, num
  );

  modport slave (
    input  start, value, frac_digits, err,
    output busy, latch, done, mode, dp, codes, num
  );

endinterface

// File: rtl/disp_formatter_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/disp_formatter.sv
// Formats a calculator result into 8 packed BCD digits or an error/overflow code.
module disp_formatter
  import disp_pkg::*;
#(
  parameter logic [3:0] CODE_ERR = DEF_CODE_ERR,
  parameter logic [3:0] CODE_OVF = DEF_CODE_OVF
) (
  input  logic            clk,
  input  logic            rst,
  disp_formatter_if.slave bus
);

  state_t             state;
  logic [VAL_W-1:0]   val_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [2:0]         frac_q;
  logic               code_path_q;
  logic [3:0]         code_q;
  logic [4:0]         iter_q;

  logic               busy_q;
  logic               latch_q;
  logic               mode_q;
  logic [2:0]         dp_q;
  logic [3:0]         codes_q;
  logic [BCD_W-1:0]   num_q;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_q[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // Request FSM: capture, convert by double dabble, emit registered result.
  // latch is registered out of EMIT, so it trails the EMIT cycle by one edge;
  // busy is held through that latch cycle so a start there is also ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      val_q       <= '0;
      bcd_q       <= '0;
      frac_q      <= '0;
      code_path_q <= 1'b0;
      code_q      <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      latch_q     <= 1'b0;
      mode_q      <= 1'b0;
      dp_q        <= '0;
      codes_q     <= '0;
      num_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          latch_q <= 1'b0;
          busy_q  <= 1'b0;
          if (bus.start && !busy_q) begin
            busy_q      <= 1'b1;
            val_q       <= bus.value;
            frac_q      <= bus.frac_digits;
            bcd_q       <= '0;
            iter_q      <= '0;
            code_path_q <= 1'b0;
            code_q      <= '0;
            if (bus.err) begin
              code_path_q <= 1'b1;
              code_q      <= CODE_ERR;
              state       <= ST_EMIT;
            end else if (bus.value > MAX_VAL) begin
              code_path_q <= 1'b1;
              code_q      <= CODE_OVF;
              state       <= ST_EMIT;
            end else begin
              state <= ST_CONVERT;
            end
          end
        end
        ST_CONVERT: begin
          // Values are bounded by MAX_VAL, so the top digit never carries out.
          assert (!bcd_adj[BCD_W-1]);
          bcd_q  <= {bcd_adj[BCD_W-2:0], val_q[VAL_W-1]};
          val_q  <= {val_q[VAL_W-2:0], 1'b0};
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'(N_ITER - 1)) state <= ST_EMIT;
        end
        ST_EMIT: begin
          latch_q <= 1'b1;
          state   <= ST_IDLE;
          if (code_path_q) begin
            mode_q  <= 1'b1;
            codes_q <= code_q;
            num_q   <= '0;
            dp_q    <= '0;
          end else begin
            mode_q  <= 1'b0;
            codes_q <= '0;
            num_q   <= bcd_q;
            dp_q    <= frac_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.latch = latch_q;
  assign bus.done  = latch_q;
  assign bus.mode  = mode_q;
  assign bus.dp    = dp_q;
  assign bus.codes = codes_q;
  assign bus.num   = num_q;

endmodule

// File: tb/tb_disp_formatter.sv
// Directed bench for disp_formatter with hand-computed expectations.
module tb_disp_formatter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;

  disp_formatter_if bus ();

  disp_formatter #(
    .CODE_ERR (4'h1),
    .CODE_OVF (4'h2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Latch is a one-cycle strobe, so it is seen at exactly one falling edge.
  always @(negedge clk) if (bus.latch) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic [26:0] v, input logic [2:0] f, input logic e,
                         input int lat, input logic m, input logic [2:0] edp,
                         input logic [3:0] ecd, input logic [31:0] enm, input bit poke);
    int n;
    int p0;
    @(negedge clk);
    p0 = pulses;
    bus.start = 1'b1; bus.value = v; bus.frac_digits = f; bus.err = e;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.latch && n < 60) begin
      if (poke && (n == 10 || n == lat - 1)) begin
        bus.start = 1'b1; bus.value = 27'd777; bus.frac_digits = 3'd6; bus.err = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1 n++;
    end
    bus.start = poke ? 1'b1 : 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("mode", 32'(bus.mode), 32'(m));
    check("dp", 32'(bus.dp), 32'(edp));
    check("codes", 32'(bus.codes), 32'(ecd));
    check("num", bus.num, enm);
    check("done", 32'(bus.done), 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("latch_drop", 32'(bus.latch), 32'd0);
    check("busy_drop", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_queue", 32'(bus.busy), 32'd0);
    check("num_hold", bus.num, enm);
    check("one_pulse", 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    int n;
    int p0;
    bus.start = 1'b0; bus.value = '0; bus.frac_digits = '0; bus.err = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_latch", 32'(bus.latch), 32'd0);
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_dp", 32'(bus.dp), 32'd0);
    check("rst_codes", 32'(bus.codes), 32'd0);
    check("rst_num", bus.num, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_req(27'd12_345_678, 3'd3, 1'b0, 28, 1'b0, 3'd3, 4'h0, 32'h1234_5678, 1'b0);
    run_req(27'd100_000_000, 3'd5, 1'b0, 1, 1'b1, 3'd0, 4'h2, 32'h0, 1'b0);
    run_req(27'd0, 3'd1, 1'b0, 28, 1'b0, 3'd1, 4'h0, 32'h0000_0000, 1'b0);
    run_req(27'd99_999_999, 3'd7, 1'b0, 28, 1'b0, 3'd7, 4'h0, 32'h9999_9999, 1'b0);
    run_req(27'd5, 3'd2, 1'b1, 1, 1'b1, 3'd0, 4'h1, 32'h0, 1'b0);
    run_req(27'd12_345_678, 3'd3, 1'b0, 28, 1'b0, 3'd3, 4'h0, 32'h1234_5678, 1'b1);

    // Abort mid-conversion with reset.
    @(negedge clk);
    p0 = pulses;
    bus.start = 1'b1; bus.value = 27'd87_654_321; bus.frac_digits = 3'd4; bus.err = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    repeat (10) begin @(posedge clk); n++; end
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_latch", 32'(bus.latch), 32'd0);
    check("abort_mode", 32'(bus.mode), 32'd0);
    check("abort_dp", 32'(bus.dp), 32'd0);
    check("abort_codes", 32'(bus.codes), 32'd0);
    check("abort_num", bus.num, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    check("abort_nolatch", 32'(pulses - p0), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);

    run_req(27'd42, 3'd0, 1'b0, 28, 1'b0, 3'd0, 4'h0, 32'h0000_0042, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_formatter.md
DISP_FORMATTER -- requirements
Module: disp_formatter

Interface
REQ-001 Parameter CODE_ERR, default 4'h1: code emitted on the codes port when the calculator reports an error.
REQ-002 Parameter CODE_OVF, default 4'h2: code emitted on the codes port when the result exceeds 8 decimal digits.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to format and send one result; sampled on the rising edge.
REQ-007 value  input  27  unsigned binary magnitude of the result.
REQ-008 frac_digits  input  3  number of digits right of the decimal point; passed through to dp.
REQ-009 err  input  1  the calculator reports an error; overrides value.
REQ-010 busy  output  1  high while a request is in progress; start is ignored while high.
REQ-011 latch  output  1  one-cycle strobe telling the display to capture mode/dp/codes/num.
REQ-012 mode  output  1  0: num holds digits, 1: codes holds a code.
REQ-013 dp  output  3  decimal point position (7: MSD, 0: LSD).
REQ-014 codes  output  4  display code, valid when mode=1.
REQ-015 num  output  32  8 packed BCD digits, digit 7 in [31:28], valid when mode=0.

Function
REQ-016 The FSM SHALL have three states: IDLE, CONVERT, EMIT.
REQ-017 In IDLE with start=1, the block SHALL capture value, frac_digits and err on that edge and set busy=1.
REQ-018 Path selection on capture, by priority:
- err=1: go to EMIT with mode=1, codes=CODE_ERR.
- else value>99_999_999: go to EMIT with mode=1, codes=CODE_OVF.
- else: go to CONVERT.
REQ-019 CONVERT SHALL run exactly 27 double-dabble iterations, one per clock:
- add 3 to each BCD digit >=5;
- then shift the 32-bit BCD register and value register left by one.
After the 27th iteration the FSM SHALL go to EMIT with mode=0 and num = BCD result.
REQ-020 EMIT SHALL last one cycle with latch=1 and done=latch. The next state SHALL be IDLE, with busy=0 from the following edge.
REQ-021 Latency: latch SHALL be high in the cycle after the 28th rising edge following the accepting edge on the numeric path, and in the cycle after the 1st edge on the code paths.
REQ-022 dp SHALL equal the captured frac_digits on the numeric path and 3'b000 on the code paths.
REQ-023 mode, dp, codes and num SHALL be registered and SHALL hold their last emitted values until the next EMIT. codes SHALL be 0 when mode=0, and num SHALL be 0 when mode=1.
REQ-024 start while busy=1, including during EMIT, SHALL be ignored and SHALL NOT be queued.
REQ-025 Boundary values on the numeric path:
- value=0 yields num=32'h0000_0000;
- value=99_999_999 yields num=32'h9999_9999;
- value=100_000_000 yields the CODE_OVF path.
REQ-026 Captured inputs SHALL be used throughout the operation; changes to value, frac_digits or err while busy SHALL have no effect.

Reset
REQ-027 On rst=1, asynchronously:
- state=IDLE;
- busy=0, latch=0, mode=0, dp=0, codes=0, num=0;
- internal shift and capture registers cleared.
REQ-028 Reset asserted mid-CONVERT or during EMIT SHALL abort the operation with no latch pulse. The first start after reset release SHALL be processed normally.

Structure
REQ-029 A shared package disp_pkg SHALL hold:
- N_DIGITS=8, VAL_W=27, MAX_VAL=99_999_999;
- default CODE_ERR/CODE_OVF values;
- the FSM state encoding.
The display consumer SHALL reuse the same code constants.
REQ-030 One combinational sub-module, bcd_digit_adj (4-bit digit in, digit+3 if >=5 out), SHALL be instantiated 8 times.

Verification
REQ-031 start with value=12_345_678, frac_digits=3, err=0 -> latch high exactly once, 28 edges after accept, with mode=0, dp=3, num=32'h1234_5678.
REQ-032 value=0, then value=99_999_999 -> num=32'h0000_0000, then num=32'h9999_9999; value=100_000_000 -> latch after 1 edge with mode=1, codes=4'h2, dp=0.
REQ-033 err=1 with value=5 -> latch after 1 edge with mode=1, codes=4'h1; err overrides value.
REQ-034 Second start pulsed during CONVERT and again during EMIT, with changed value -> exactly one latch, carrying the first value; busy drops after EMIT.
REQ-035 rst pulsed at iteration 10 of CONVERT -> all outputs zero, no latch; a subsequent start with value=42 -> num=32'h0000_0042.
